writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued write entries; power of two, 2..16.
REQ-002 Parameter DATA_W, default 32, width of write data.
REQ-003 Parameter ADDR_W, default 5, register index width, for 32 registers.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  producer presents a write request.
REQ-007 in_ready  output  1  queue can accept a request this cycle.
REQ-008 in_reg  input  ADDR_W  destination register index.
REQ-009 in_data  input  DATA_W  value to write.
REQ-010 drain_stall  input  1  register file write port unavailable this cycle.
REQ-011 RegWrite  output  1  write strobe to register file.
REQ-012 WriteRegister  output  ADDR_W  register file write index.
REQ-013 WriteData  output  DATA_W  register file write data.
REQ-014 ReadRegister1, ReadRegister2  input  ADDR_W each  read indices also presented to the register file.
REQ-015 fwd_hit1, fwd_hit2  output  1 each  the queue holds a pending write to the matching read index.
REQ-016 fwd_data1, fwd_data2  output  DATA_W each  youngest pending data for the matching read index.
REQ-017 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Circular FIFO with head and tail pointers that wrap modulo DEPTH; entries drain strictly in arrival order.
REQ-019 in_ready = (count != DEPTH), combinational from registered count only, with no dependence on in_valid.
REQ-020 Enqueue occurs on an edge where in_valid && in_ready && in_reg != 0.
REQ-021 A handshake with in_reg == 0 completes normally but is discarded: no entry, no count change.
REQ-022 RegWrite = (count != 0) && !drain_stall; WriteRegister and WriteData are driven from the head entry.
REQ-023 Dequeue occurs on every edge where RegWrite is 1.
REQ-024 When the queue is empty, WriteRegister and WriteData are 0.
REQ-025 Latency: a request accepted at edge N drives RegWrite during cycle N..N+1 and is written to the register file at edge N+1 at the earliest; there is no same-cycle pass-through.
REQ-026 On the same edge, push and pop both occur when conditions allow; count is unchanged and both pointers advance.
REQ-027 When full, in_ready is 0, even if a pop occurs that cycle.
REQ-028 When empty with drain_stall 0 and a push in the same cycle, the entry is only pushed; it pops on a later edge.
REQ-029 count never exceeds DEPTH or underflows below 0.
REQ-030 Forwarding: fwd_hitK = 1 if any occupied entry has reg == ReadRegisterK and ReadRegisterK != 0.
REQ-031 fwd_dataK is the data of the youngest (closest-to-tail) such entry; otherwise fwd_dataK is 0.
REQ-032 Forwarding outputs are combinational from stored entries; they do not reflect the request being presented in the same cycle.

Reset
REQ-033 At a rising edge with reset == 0: count = 0, head = tail = 0, and all entry valid state is cleared.
REQ-034 During and after reset: RegWrite = 0, WriteRegister = 0, WriteData = 0, fwd_hit1/2 = 0, fwd_data1/2 = 0, in_ready = 1.
REQ-035 Reset asserted mid-operation discards all pending entries; no partial or further writes issue.
REQ-036 in_valid is ignored on any edge where reset == 0.

Configuration
REQ-037 Macro WBQ_FORWARD_EN: when defined, forwarding logic per REQ-030..032 is built.
REQ-038 When WBQ_FORWARD_EN is undefined: fwd_hit1/2 and fwd_data1/2 are tied to 0, no comparators are built, and all other behaviour is identical.

Verification
REQ-039 Reset, then push (reg 3, 0xDEADBEEF) -> next cycle RegWrite = 1, WriteRegister = 3, WriteData = 0xDEADBEEF, count = 1; after the following edge, count = 0.
REQ-040 drain_stall = 1, push 5 requests -> count reaches 4, in_ready = 0, 5th request held; release stall -> writes issue in order, one per cycle, then the 5th is accepted.
REQ-041 drain_stall = 1, push (reg 7, 0x11), then (reg 7, 0x22); ReadRegister1 = 7 -> fwd_hit1 = 1, fwd_data1 = 0x22; ReadRegister2 = 8 -> fwd_hit2 = 0, fwd_data2 = 0 (with WBQ_FORWARD_EN undefined: both hits are 0).
REQ-042 Push (reg 0, 0x55) -> handshake completes, count stays 0, RegWrite never asserts.
REQ-043 count = 2 with continuous push and drain over 10 cycles -> count stays 2, pointers wrap, write order matches push order.
REQ-044 count = 3 with stall, then assert reset for one edge -> count = 0, RegWrite = 0, in_ready = 1; the stale entries are never written.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: in-order register-file writeback FIFO with read forwarding.
// Define WBQ_FORWARD_EN to build the forwarding comparators; otherwise fwd_* are 0.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_reg,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    drain_stall,
  output logic                    RegWrite,
  output logic [ADDR_W-1:0]       WriteRegister,
  output logic [DATA_W-1:0]       WriteData,
  input  logic [ADDR_W-1:0]       ReadRegister1,
  input  logic [ADDR_W-1:0]       ReadRegister2,
  output logic                    fwd_hit1,
  output logic                    fwd_hit2,
  output logic [DATA_W-1:0]       fwd_data1,
  output logic [DATA_W-1:0]       fwd_data2,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          live;
  logic          push;
  logic          pop;

  // live gates every write-side output so nothing issues while reset is low
  assign live     = reset && (count_q != '0);
  assign in_ready = (count_q != CW'(DEPTH));
  assign pop      = live && !drain_stall;
  assign push     = reset && in_valid && in_ready && (in_reg != '0);

  assign count         = count_q;
  assign RegWrite      = pop;
  assign WriteRegister = live ? ent_q[head_q].rd   : '0;
  assign WriteData     = live ? ent_q[head_q].data : '0;

  // next-state: write at tail, retire at head, occupancy tracks both
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      ent_d[tail_q] = '{rd: in_reg, data: in_data};
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // state register; entry storage needs no reset since count defines occupancy
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef WBQ_FORWARD_EN
  // scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (reset && (CW'(i) < count_q)) begin
        if (ReadRegister1 != '0 &&
            ent_q[head_q + PW'(i)].rd == ReadRegister1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = ent_q[head_q + PW'(i)].data;
        end
        if (ReadRegister2 != '0 &&
            ent_q[head_q + PW'(i)].rd == ReadRegister2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = ent_q[head_q + PW'(i)].data;
        end
      end
    end
  end
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^{ReadRegister1, ReadRegister2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed and random stimulus against a queue-based
// reference model of the writeback queue.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [AW-1:0]          in_reg;
  logic [DW-1:0]          in_data;
  logic                   drain_stall;
  logic                   RegWrite;
  logic [AW-1:0]          WriteRegister;
  logic [DW-1:0]          WriteData;
  logic [AW-1:0]          ReadRegister1;
  logic [AW-1:0]          ReadRegister2;
  logic                   fwd_hit1;
  logic                   fwd_hit2;
  logic [DW-1:0]          fwd_data1;
  logic [DW-1:0]          fwd_data2;
  logic [$clog2(DEPTH):0] count;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_reg(in_reg),
    .in_data(in_data),
    .drain_stall(drain_stall),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .fwd_hit1(fwd_hit1),
    .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1),
    .fwd_data2(fwd_data2),
    .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // forwarding lookup: youngest pending write to index r, searched from the back
  task automatic fwd_model(input logic rst, input logic [AW-1:0] r,
                           output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WBQ_FORWARD_EN
    if (rst && r != '0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].rd == r) begin
          hit = 1'b1;
          d   = q[i].data;
          break;
        end
      end
    end
`endif
  endtask

  // one cycle: drive, check outputs against the model, advance model, clock
  task automatic step(input logic v, input logic [AW-1:0] r,
                      input logic [DW-1:0] d, input logic st,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic rst, output logic acc);
    logic          e_ready;
    logic          e_rw;
    logic          e_live;
    logic [AW-1:0] e_wr;
    logic [DW-1:0] e_wd;
    logic          e_h1, e_h2;
    logic [DW-1:0] e_d1, e_d2;
    in_valid      = v;
    in_reg        = r;
    in_data       = d;
    drain_stall   = st;
    ReadRegister1 = r1;
    ReadRegister2 = r2;
    reset         = rst;
    #1;
    e_ready = (q.size() != DEPTH);
    e_live  = rst && (q.size() != 0);
    e_rw    = e_live && !st;
    e_wr    = e_live ? q[0].rd   : '0;
    e_wd    = e_live ? q[0].data : '0;
    fwd_model(rst, r1, e_h1, e_d1);
    fwd_model(rst, r2, e_h2, e_d2);
    chk("in_ready", 64'(in_ready), 64'(e_ready));
    chk("count", 64'(count), 64'(q.size()));
    chk("RegWrite", 64'(RegWrite), 64'(e_rw));
    chk("WriteRegister", 64'(WriteRegister), 64'(e_wr));
    chk("WriteData", 64'(WriteData), 64'(e_wd));
    chk("fwd_hit1", 64'(fwd_hit1), 64'(e_h1));
    chk("fwd_data1", 64'(fwd_data1), 64'(e_d1));
    chk("fwd_hit2", 64'(fwd_hit2), 64'(e_h2));
    chk("fwd_data2", 64'(fwd_data2), 64'(e_d2));
    acc = rst && v && e_ready;
    if (!rst) begin
      q.delete();
    end else begin
      if (e_rw) void'(q.pop_front());
      if (acc && r != '0) q.push_back('{rd: r, data: d});
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic acc;
    logic held;
    in_valid = 0; in_reg = 0; in_data = 0; drain_stall = 0;
    ReadRegister1 = 0; ReadRegister2 = 0; reset = 0;
    @(posedge clk);
    #2;
    step(0, 0, 0, 0, 0, 0, 0, acc);
    step(1, 3, 32'h1234, 0, 3, 3, 0, acc);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);

    // single push, written the following edge
    step(1, 3, 32'hDEADBEEF, 0, 0, 0, 1, acc);
    chk("r039_rw", 64'(RegWrite), 64'd1);
    chk("r039_wr", 64'(WriteRegister), 64'd3);
    chk("r039_wd", 64'(WriteData), 64'hDEADBEEF);
    chk("r039_cnt", 64'(count), 64'd1);
    step(0, 0, 0, 0, 0, 0, 1, acc);
    chk("r039_cnt0", 64'(count), 64'd0);

    // fill under stall, fifth request held until space frees
    for (int i = 1; i <= 4; i++)
      step(1, AW'(i), DW'(i * 16), 1, 0, 0, 1, acc);
    chk("r040_full_ready", 64'(in_ready), 64'd0);
    chk("r040_full_cnt", 64'(count), 64'd4);
    step(1, 5, 32'h50, 1, 0, 0, 1, acc);
    held = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(held, 5, 32'h50, 0, 0, 0, 1, acc);
      if (acc) held = 1'b0;
    end
    chk("r040_drained", 64'(count), 64'd0);

    // two writes to r7 pending; forwarding picks the younger
    step(1, 7, 32'h11, 1, 7, 8, 1, acc);
    step(1, 7, 32'h22, 1, 7, 8, 1, acc);
    step(0, 0, 0, 1, 7, 8, 1, acc);
`ifdef WBQ_FORWARD_EN
    chk("r041_hit1", 64'(fwd_hit1), 64'd1);
    chk("r041_d1", 64'(fwd_data1), 64'h22);
`else
    chk("r041_hit1", 64'(fwd_hit1), 64'd0);
    chk("r041_d1", 64'(fwd_data1), 64'd0);
`endif
    chk("r041_hit2", 64'(fwd_hit2), 64'd0);
    chk("r041_d2", 64'(fwd_data2), 64'd0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 7, 8, 1, acc);

    // writes to r0 are accepted and dropped
    step(1, 0, 32'h55, 0, 0, 0, 1, acc);
    chk("r042_cnt", 64'(count), 64'd0);
    chk("r042_rw", 64'(RegWrite), 64'd0);
    step(0, 0, 0, 0, 0, 0, 1, acc);

    // steady state at occupancy 2 with wrap-around
    step(1, 9, 32'h900, 1, 0, 0, 1, acc);
    step(1, 10, 32'hA00, 1, 0, 0, 1, acc);
    for (int k = 0; k < 10; k++)
      step(1, AW'(11 + k), DW'(32'hB00 + k), 0, AW'(11 + k), 9, 1, acc);
    chk("r043_cnt", 64'(count), 64'd2);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 1, acc);

    // reset mid-flight discards pending entries
    for (int i = 0; i < 3; i++)
      step(1, AW'(20 + i), DW'(32'hC0 + i), 1, 20, 21, 1, acc);
    step(1, 25, 32'hEE, 0, 20, 21, 0, acc);
    chk("r044_cnt", 64'(count), 64'd0);
    chk("r044_ready", 64'(in_ready), 64'd1);
    step(0, 0, 0, 0, 20, 21, 1, acc);
    chk("r044_rw", 64'(RegWrite), 64'd0);

    // random traffic
    for (int k = 0; k < 400; k++)
      step(($urandom % 4) != 0, AW'($urandom % 8), $urandom,
           ($urandom % 3) == 0, AW'($urandom % 8), AW'($urandom % 8),
           ($urandom % 50) != 0, acc);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
